// File: rtl/ptw_sv39.sv
// Sv39 page-table walker: TLB miss in, PTE reads out, TLB update or fault back.
// Optional perf counters are built only when PTW_PERF_CNT_EN is defined.
module ptw_sv39 #(
    parameter int PADDR_W = 56,
    parameter int LEVELS  = 3
) (
    input  logic               clk_i,
    input  logic               srst_n_i,
    input  logic               tlb_flush_i,
    input  logic [43:0]        satp_ppn_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [26:0]        req_vpn_i,
    output logic               mem_req_valid_o,
    input  logic               mem_req_ready_i,
    output logic [PADDR_W-1:0] mem_req_addr_o,
    input  logic               mem_rsp_valid_i,
    input  logic [63:0]        mem_rsp_data_i,
    input  logic               mem_rsp_err_i,
    output logic               update_valid_o,
    output logic               update_we_o,
    output logic [1:0]         update_level_o,
    output logic [26:0]        update_vpn_o,
    output logic [25:0]        update_ppn2_o,
    output logic [8:0]         update_ppn1_o,
    output logic [8:0]         update_ppn0_o,
    output logic [7:0]         update_pte_o,
    output logic               walk_done_o,
    output logic               page_fault_o,
    output logic               access_fault_o
`ifdef PTW_PERF_CNT_EN
    ,
    output logic [31:0]        perf_walk_cnt_o,
    output logic [31:0]        perf_fault_cnt_o
`endif
);

    localparam int AW = (PADDR_W > 56) ? PADDR_W : 56;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [26:0] vpn_q, vpn_d;
    logic [43:0] a_q, a_d;
    logic [1:0]  level_q, level_d;
    logic [63:0] pte_q, pte_d;
    logic        err_q, err_d;
    logic        pf_q, pf_d;
    logic        af_q, af_d;
    logic        ok_q, ok_d;

    logic [8:0]    vpn_idx_s;
    logic [AW-1:0] base_s;
    logic [AW-1:0] offs_s;
    logic [AW-1:0] addr_full_s;
    logic          leaf_s;
    logic          bad_fmt_s;
    logic          misalign_s;
    logic          accept_s;
    logic          done_s;
    logic          upd_s;
    logic          unused_rsw_s;

    // VPN slice selected by the current level
    always_comb begin
        case (level_q)
            2'd2:    vpn_idx_s = vpn_q[26:18];
            2'd1:    vpn_idx_s = vpn_q[17:9];
            default: vpn_idx_s = vpn_q[8:0];
        endcase
    end

    // PTE address = table base + 8 * index, computed wide then truncated
    always_comb begin
        base_s        = '0;
        offs_s        = '0;
        base_s[55:0]  = {a_q, 12'h000};
        offs_s[11:0]  = {vpn_idx_s, 3'b000};
        addr_full_s   = base_s + offs_s;
    end

    // PTE classification for the CHECK state
    always_comb begin
        leaf_s    = pte_q[1] | pte_q[3];
        bad_fmt_s = (~pte_q[0]) | ((~pte_q[1]) & pte_q[2]) | (pte_q[63:54] != 10'd0);
        case (level_q)
            2'd2:    misalign_s = (pte_q[27:10] != 18'd0);
            2'd1:    misalign_s = (pte_q[18:10] != 9'd0);
            default: misalign_s = 1'b0;
        endcase
    end

    assign accept_s     = (state_q == S_IDLE) && req_valid_i && !tlb_flush_i;
    assign unused_rsw_s = ^pte_q[9:8];

    // Next-state and walk bookkeeping
    always_comb begin
        state_d = state_q;
        vpn_d   = vpn_q;
        a_d     = a_q;
        level_d = level_q;
        pte_d   = pte_q;
        err_d   = err_q;
        pf_d    = pf_q;
        af_d    = af_q;
        ok_d    = ok_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    vpn_d   = req_vpn_i;
                    a_d     = satp_ppn_i;
                    level_d = 2'd2;
                    pf_d    = 1'b0;
                    af_d    = 1'b0;
                    ok_d    = 1'b0;
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                // A request accepted in the flush cycle still owes us a response
                if (tlb_flush_i) begin
                    state_d = mem_req_ready_i ? S_DRAIN : S_IDLE;
                end else if (mem_req_ready_i) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid_i) begin
                    pte_d   = mem_rsp_data_i;
                    err_d   = mem_rsp_err_i;
                    state_d = tlb_flush_i ? S_IDLE : S_CHECK;
                end else if (tlb_flush_i) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_CHECK: begin
                if (tlb_flush_i) begin
                    state_d = S_IDLE;
                end else if (err_q) begin
                    af_d    = 1'b1;
                    state_d = S_DONE;
                end else if (bad_fmt_s) begin
                    pf_d    = 1'b1;
                    state_d = S_DONE;
                end else if (leaf_s) begin
                    // A/D are software-managed: a clear A bit faults, D is not examined
                    if (misalign_s || !pte_q[6]) begin
                        pf_d = 1'b1;
                    end else begin
                        ok_d = 1'b1;
                    end
                    state_d = S_DONE;
                end else if (level_q == 2'd0) begin
                    pf_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    a_d     = pte_q[53:10];
                    level_d = level_q - 2'd1;
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (mem_rsp_valid_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and walk registers
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_q <= S_IDLE;
            vpn_q   <= 27'd0;
            a_q     <= 44'd0;
            level_q <= 2'd0;
            pte_q   <= 64'd0;
            err_q   <= 1'b0;
            pf_q    <= 1'b0;
            af_q    <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            vpn_q   <= vpn_d;
            a_q     <= a_d;
            level_q <= level_d;
            pte_q   <= pte_d;
            err_q   <= err_d;
            pf_q    <= pf_d;
            af_q    <= af_d;
            ok_q    <= ok_d;
        end
    end

    assign done_s          = (state_q == S_DONE);
    assign upd_s           = done_s && ok_q;
    assign req_ready_o     = (state_q == S_IDLE) && !tlb_flush_i;
    assign mem_req_valid_o = (state_q == S_REQ);
    assign mem_req_addr_o  = (state_q == S_REQ) ? addr_full_s[PADDR_W-1:0] : '0;
    assign walk_done_o     = done_s;
    assign page_fault_o    = done_s && pf_q;
    assign access_fault_o  = done_s && af_q;
    assign update_valid_o  = upd_s;
    assign update_we_o     = upd_s;
    assign update_level_o  = upd_s ? level_q       : 2'd0;
    assign update_vpn_o    = upd_s ? vpn_q         : 27'd0;
    assign update_ppn2_o   = upd_s ? pte_q[53:28]  : 26'd0;
    assign update_ppn1_o   = upd_s ? pte_q[27:19]  : 9'd0;
    assign update_ppn0_o   = upd_s ? pte_q[18:10]  : 9'd0;
    assign update_pte_o    = upd_s ? pte_q[7:0]    : 8'd0;

`ifdef PTW_PERF_CNT_EN
    logic [31:0] walk_cnt_q, walk_cnt_d;
    logic [31:0] fault_cnt_q, fault_cnt_d;

    // Walk and fault event counters, free-running with natural wrap
    always_comb begin
        walk_cnt_d  = walk_cnt_q;
        fault_cnt_d = fault_cnt_q;
        if (done_s) begin
            walk_cnt_d = walk_cnt_q + 32'd1;
            if (pf_q || af_q) begin
                fault_cnt_d = fault_cnt_q + 32'd1;
            end else begin
                fault_cnt_d = fault_cnt_q;
            end
        end else begin
            walk_cnt_d = walk_cnt_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            walk_cnt_q  <= 32'd0;
            fault_cnt_q <= 32'd0;
        end else begin
            walk_cnt_q  <= walk_cnt_d;
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign perf_walk_cnt_o  = walk_cnt_q;
    assign perf_fault_cnt_o = fault_cnt_q;
`else
    // Counters not built in this configuration
`endif

    ptw_sv39_chk #(
        .PADDR_W (PADDR_W),
        .LEVELS  (LEVELS)
    ) u_chk (
        .clk_i           (clk_i),
        .srst_n_i        (srst_n_i),
        .tlb_flush_i     (tlb_flush_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o)
    );

endmodule

// Protocol checker for the walker: fixed depth and stable request while stalled.
module ptw_sv39_chk #(
    parameter int PADDR_W = 56,
    parameter int LEVELS  = 3
) (
    input  logic               clk_i,
    input  logic               srst_n_i,
    input  logic               tlb_flush_i,
    input  logic               mem_req_valid_o,
    input  logic               mem_req_ready_i,
    input  logic [PADDR_W-1:0] mem_req_addr_o
);

    a_levels: assert property (@(posedge clk_i) LEVELS == 3);

    a_req_stable: assert property (@(posedge clk_i) disable iff (!srst_n_i)
        (mem_req_valid_o && !mem_req_ready_i && !tlb_flush_i)
        |=> (mem_req_valid_o && $stable(mem_req_addr_o)));

endmodule

// File: tb/tb_ptw_sv39.sv
// Directed bench for ptw_sv39: table of single walks plus flush, reset and stall sequences.
module tb_ptw_sv39;

    logic        clk = 1'b0;
    logic        srst_n_i, tlb_flush_i, req_valid_i, req_ready_o;
    logic [43:0] satp_ppn_i;
    logic [26:0] req_vpn_i;
    logic        mem_req_valid_o, mem_req_ready_i;
    logic [55:0] mem_req_addr_o;
    logic        mem_rsp_valid_i, mem_rsp_err_i;
    logic [63:0] mem_rsp_data_i;
    logic        update_valid_o, update_we_o;
    logic [1:0]  update_level_o;
    logic [26:0] update_vpn_o;
    logic [25:0] update_ppn2_o;
    logic [8:0]  update_ppn1_o, update_ppn0_o;
    logic [7:0]  update_pte_o;
    logic        walk_done_o, page_fault_o, access_fault_o;
`ifdef PTW_PERF_CNT_EN
    logic [31:0] perf_walk_cnt_o, perf_fault_cnt_o;
`endif

    always #5 clk = ~clk;

    ptw_sv39 dut (
        .clk_i           (clk),
        .srst_n_i        (srst_n_i),
        .tlb_flush_i     (tlb_flush_i),
        .satp_ppn_i      (satp_ppn_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_vpn_i       (req_vpn_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .mem_rsp_err_i   (mem_rsp_err_i),
        .update_valid_o  (update_valid_o),
        .update_we_o     (update_we_o),
        .update_level_o  (update_level_o),
        .update_vpn_o    (update_vpn_o),
        .update_ppn2_o   (update_ppn2_o),
        .update_ppn1_o   (update_ppn1_o),
        .update_ppn0_o   (update_ppn0_o),
        .update_pte_o    (update_pte_o),
        .walk_done_o     (walk_done_o),
        .page_fault_o    (page_fault_o),
        .access_fault_o  (access_fault_o)
`ifdef PTW_PERF_CNT_EN
        ,
        .perf_walk_cnt_o (perf_walk_cnt_o),
        .perf_fault_cnt_o(perf_fault_cnt_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Memory model: read k of a walk returns pte_tab[k]; optional stall and response delay
    logic [63:0] pte_tab [3];
    logic        err_tab [3];
    logic [55:0] addr_log [3];
    int          nreads = 0;
    int          stall_left = 0;
    int          rsp_delay = 0;
    int          rsp_wait = 0;
    int          rsp_idx = 0;
    bit          pending = 1'b0;

    initial begin
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_err_i   = 1'b0;
        mem_rsp_data_i  = 64'd0;
        forever begin
            @(negedge clk);
            mem_rsp_valid_i = 1'b0;
            mem_rsp_err_i   = 1'b0;
            mem_rsp_data_i  = 64'd0;
            if (pending) begin
                if (rsp_wait == 0) begin
                    mem_rsp_valid_i = 1'b1;
                    mem_rsp_data_i  = pte_tab[rsp_idx];
                    mem_rsp_err_i   = err_tab[rsp_idx];
                    pending = 1'b0;
                end else begin
                    rsp_wait--;
                end
            end
            mem_req_ready_i = 1'b0;
            if (mem_req_valid_o && !pending) begin
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    mem_req_ready_i = 1'b1;
                    rsp_idx = (nreads < 3) ? nreads : 2;
                    addr_log[rsp_idx] = mem_req_addr_o;
                    nreads++;
                    pending  = 1'b1;
                    rsp_wait = rsp_delay;
                end
            end
        end
    end

    // Results of the most recent walk
    int          r_done_cnt, r_done_cyc, r_upd_cnt, r_first_ready, r_req_cycles, r_addr_chg, r_we_bad;
    logic        r_pf, r_af;
    logic [1:0]  r_lvl;
    logic [26:0] r_vpn;
    logic [25:0] r_ppn2;
    logic [8:0]  r_ppn1, r_ppn0;
    logic [7:0]  r_pte;

    // Cycle 0 = accept cycle; cycles 1..ncyc are observed at negedge+1
    task automatic do_walk(input logic [26:0] vpn, input logic [43:0] satp,
                           input int flush_at, input int rst_at, input int ncyc);
        logic        prev_v, prev_rdy;
        logic [55:0] prev_a;
        r_done_cnt = 0; r_done_cyc = 0; r_upd_cnt = 0; r_first_ready = 0;
        r_req_cycles = 0; r_addr_chg = 0; r_we_bad = 0;
        r_pf = 1'b0; r_af = 1'b0; r_lvl = 2'd0; r_vpn = 27'd0;
        r_ppn2 = 26'd0; r_ppn1 = 9'd0; r_ppn0 = 9'd0; r_pte = 8'd0;
        nreads = 0;
        prev_v = 1'b0; prev_rdy = 1'b0; prev_a = 56'd0;
        @(negedge clk); #1;
        req_valid_i = 1'b1; req_vpn_i = vpn; satp_ppn_i = satp;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk); #1;
            if (walk_done_o) begin
                r_done_cnt++;
                if (r_done_cyc == 0) begin
                    r_done_cyc = c;
                    r_pf = page_fault_o; r_af = access_fault_o; r_lvl = update_level_o;
                    r_vpn = update_vpn_o; r_ppn2 = update_ppn2_o; r_ppn1 = update_ppn1_o;
                    r_ppn0 = update_ppn0_o; r_pte = update_pte_o;
                end
            end
            if (update_valid_o) r_upd_cnt++;
            if (update_we_o !== update_valid_o) r_we_bad++;
            if (req_ready_o && r_first_ready == 0) r_first_ready = c;
            if (mem_req_valid_o) begin
                r_req_cycles++;
                if (prev_v && !prev_rdy && mem_req_addr_o !== prev_a) r_addr_chg++;
            end
            prev_v = mem_req_valid_o; prev_a = mem_req_addr_o; prev_rdy = mem_req_ready_i;
            req_valid_i = 1'b0;
            tlb_flush_i = (c == flush_at);
            srst_n_i    = !(c == rst_at);
        end
        tlb_flush_i = 1'b0;
        srst_n_i    = 1'b1;
    endtask

    typedef struct {
        logic [26:0] vpn;
        logic [43:0] satp;
        logic [63:0] pte0, pte1, pte2;
        logic        err0;
        int          nrd;
        logic [55:0] ad0, ad1, ad2;
        int          done_cyc;
        logic        upd;
        logic [1:0]  lvl;
        logic        pf, af;
        logic [25:0] ppn2;
        logic [8:0]  ppn1, ppn0;
        logic [7:0]  pte8;
    } vec_t;

    vec_t vecs[$];
    int   exp_walks = 0;
    int   exp_faults = 0;

    initial begin
        srst_n_i = 1'b0; tlb_flush_i = 1'b0; req_valid_i = 1'b0;
        req_vpn_i = 27'd0; satp_ppn_i = 44'd0;
        for (int k = 0; k < 3; k++) begin pte_tab[k] = 64'd0; err_tab[k] = 1'b0; end

        // Order: vpn satp pte0 pte1 pte2 err0 nrd ad0 ad1 ad2 done upd lvl pf af ppn2 ppn1 ppn0 pte8
        vecs.push_back('{27'h1, 44'h80000, 64'h20000401, 64'h20000801, 64'h200000CF, 1'b0, 32'd3,
            56'h80000000, 56'h80001000, 56'h80002008, 32'd10, 1'b1, 2'd0, 1'b0, 1'b0, 26'h2, 9'h0, 9'h0, 8'hCF});
        vecs.push_back('{27'hC0000, 44'h80000, 64'hCF, 64'h0, 64'h0, 1'b0, 32'd1,
            56'h80000018, 56'h0, 56'h0, 32'd4, 1'b1, 2'd2, 1'b0, 1'b0, 26'h0, 9'h0, 9'h0, 8'hCF});
        vecs.push_back('{27'h1, 44'h80000, 64'h20000401, 64'h4CF, 64'h0, 1'b0, 32'd2,
            56'h80000000, 56'h80001000, 56'h0, 32'd7, 1'b0, 2'd0, 1'b1, 1'b0, 26'h0, 9'h0, 9'h0, 8'h0});
        vecs.push_back('{27'h1, 44'h80000, 64'h20000401, 64'h20000801, 64'h1, 1'b0, 32'd3,
            56'h80000000, 56'h80001000, 56'h80002008, 32'd10, 1'b0, 2'd0, 1'b1, 1'b0, 26'h0, 9'h0, 9'h0, 8'h0});
        vecs.push_back('{27'h1, 44'h80000, 64'hCF, 64'h0, 64'h0, 1'b1, 32'd1,
            56'h80000000, 56'h0, 56'h0, 32'd4, 1'b0, 2'd0, 1'b0, 1'b1, 26'h0, 9'h0, 9'h0, 8'h0});
        vecs.push_back('{27'h1, 44'h80000, 64'hCE, 64'h0, 64'h0, 1'b0, 32'd1,
            56'h80000000, 56'h0, 56'h0, 32'd4, 1'b0, 2'd0, 1'b1, 1'b0, 26'h0, 9'h0, 9'h0, 8'h0});
        vecs.push_back('{27'h1, 44'h80000, 64'h05, 64'h0, 64'h0, 1'b0, 32'd1,
            56'h80000000, 56'h0, 56'h0, 32'd4, 1'b0, 2'd0, 1'b1, 1'b0, 26'h0, 9'h0, 9'h0, 8'h0});
        vecs.push_back('{27'h1, 44'h80000, 64'h00400000000000CF, 64'h0, 64'h0, 1'b0, 32'd1,
            56'h80000000, 56'h0, 56'h0, 32'd4, 1'b0, 2'd0, 1'b1, 1'b0, 26'h0, 9'h0, 9'h0, 8'h0});
        vecs.push_back('{27'h1, 44'h80000, 64'h8F, 64'h0, 64'h0, 1'b0, 32'd1,
            56'h80000000, 56'h0, 56'h0, 32'd4, 1'b0, 2'd0, 1'b1, 1'b0, 26'h0, 9'h0, 9'h0, 8'h0});
        vecs.push_back('{27'hA07, 44'h80000, 64'h20000401, 64'h300800CF, 64'h0, 1'b0, 32'd2,
            56'h80000000, 56'h80001028, 56'h0, 32'd7, 1'b1, 2'd1, 1'b0, 1'b0, 26'h3, 9'h1, 9'h0, 8'hCF});
        vecs.push_back('{27'h1, 44'h80000, 64'h800CF, 64'h0, 64'h0, 1'b0, 32'd1,
            56'h80000000, 56'h0, 56'h0, 32'd4, 1'b0, 2'd0, 1'b1, 1'b0, 26'h0, 9'h0, 9'h0, 8'h0});
        vecs.push_back('{27'h7FC0000, 44'h12345, 64'h400000DF, 64'h0, 64'h0, 1'b0, 32'd1,
            56'h12345FF8, 56'h0, 56'h0, 32'd4, 1'b1, 2'd2, 1'b0, 1'b0, 26'h4, 9'h0, 9'h0, 8'hDF});

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready_o, 1'b1);
        chk("rst_mem_valid", mem_req_valid_o, 1'b0);
        chk("rst_mem_addr", mem_req_addr_o, 56'd0);
        chk("rst_done", walk_done_o, 1'b0);
        chk("rst_update", update_valid_o, 1'b0);
        chk("rst_faults", {page_fault_o, access_fault_o}, 2'b00);
        chk("rst_update_pte", update_pte_o, 8'd0);
        srst_n_i = 1'b1;

        // Flush and request together in IDLE: flush wins
        @(negedge clk); #1;
        req_valid_i = 1'b1; tlb_flush_i = 1'b1; req_vpn_i = 27'h1; satp_ppn_i = 44'h80000;
        #1 chk("flush_idle_ready", req_ready_o, 1'b0);
        @(negedge clk); #1;
        chk("flush_idle_no_req", mem_req_valid_o, 1'b0);
        req_valid_i = 1'b0; tlb_flush_i = 1'b0;
        #1 chk("flush_idle_ready_back", req_ready_o, 1'b1);

        // Synchronous reset in WAIT; stray response later must be ignored
        pte_tab[0] = 64'hCF; err_tab[0] = 1'b0; rsp_delay = 2;
        do_walk(27'h1, 44'h80000, 0, 2, 14);
        chk("srst_no_done", r_done_cnt, 0);
        chk("srst_no_update", r_upd_cnt, 0);
        chk("srst_ready_cycle", r_first_ready, 3);
        rsp_delay = 0;

        foreach (vecs[i]) begin
            pte_tab[0] = vecs[i].pte0; pte_tab[1] = vecs[i].pte1; pte_tab[2] = vecs[i].pte2;
            err_tab[0] = vecs[i].err0; err_tab[1] = 1'b0; err_tab[2] = 1'b0;
            do_walk(vecs[i].vpn, vecs[i].satp, 0, 0, 14);
            chk($sformatf("v%0d_reads", i), nreads, vecs[i].nrd);
            chk($sformatf("v%0d_req_cycles", i), r_req_cycles, vecs[i].nrd);
            chk($sformatf("v%0d_addr0", i), addr_log[0], vecs[i].ad0);
            if (vecs[i].nrd > 1) chk($sformatf("v%0d_addr1", i), addr_log[1], vecs[i].ad1);
            if (vecs[i].nrd > 2) chk($sformatf("v%0d_addr2", i), addr_log[2], vecs[i].ad2);
            chk($sformatf("v%0d_done_cnt", i), r_done_cnt, 1);
            chk($sformatf("v%0d_done_cyc", i), r_done_cyc, vecs[i].done_cyc);
            chk($sformatf("v%0d_ready_after", i), r_first_ready, vecs[i].done_cyc + 1);
            chk($sformatf("v%0d_upd_cnt", i), r_upd_cnt, vecs[i].upd ? 1 : 0);
            chk($sformatf("v%0d_we", i), r_we_bad, 0);
            chk($sformatf("v%0d_pf", i), r_pf, vecs[i].pf);
            chk($sformatf("v%0d_af", i), r_af, vecs[i].af);
            if (vecs[i].upd) begin
                chk($sformatf("v%0d_level", i), r_lvl, vecs[i].lvl);
                chk($sformatf("v%0d_vpn", i), r_vpn, vecs[i].vpn);
                chk($sformatf("v%0d_ppn2", i), r_ppn2, vecs[i].ppn2);
                chk($sformatf("v%0d_ppn1", i), r_ppn1, vecs[i].ppn1);
                chk($sformatf("v%0d_ppn0", i), r_ppn0, vecs[i].ppn0);
                chk($sformatf("v%0d_pte", i), r_pte, vecs[i].pte8);
            end
            exp_walks++;
            if (vecs[i].pf || vecs[i].af) exp_faults++;
        end

        // Flush while waiting for the response, response arrives later
        pte_tab[0] = 64'hCF; err_tab[0] = 1'b0; rsp_delay = 5;
        do_walk(27'h1, 44'h80000, 2, 0, 14);
        chk("drain_no_done", r_done_cnt, 0);
        chk("drain_no_update", r_upd_cnt, 0);
        chk("drain_ready_cycle", r_first_ready, 8);
        chk("drain_reads", nreads, 1);
        rsp_delay = 0;

        // Memory stalls the request for 7 cycles
        stall_left = 7;
        do_walk(27'h1, 44'h80000, 0, 0, 16);
        chk("stall_req_cycles", r_req_cycles, 8);
        chk("stall_addr_changes", r_addr_chg, 0);
        chk("stall_addr", addr_log[0], 56'h80000000);
        chk("stall_done_cyc", r_done_cyc, 11);
        chk("stall_update", r_upd_cnt, 1);
        exp_walks++;

`ifdef PTW_PERF_CNT_EN
        @(negedge clk); #1;
        chk("perf_walk_cnt", perf_walk_cnt_o, exp_walks);
        chk("perf_fault_cnt", perf_fault_cnt_o, exp_faults);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
